vipitc_ctrl_sequencer: RTL
==========================

Name: vipitc_ctrl_sequencer

Overview:
- Avalon-MM master that configures and sequences the clocked-video-output control slave (go/status/interrupt/register bank at word addresses 0/1/2/3+).
- On a start request: stops the slave, polls status until stopped, writes the NO_REGISTERS config words, then re-enables with the chosen interrupt enables.
- While idle, services slave interrupts (read, report, write-to-clear) so the host-facing side sees simple pulses.

Parameters:
- AV_ADDRESS_WIDTH, 5, slave word-address width
- AV_DATA_WIDTH, 16, slave data width
- NO_REGISTERS, 4, config words written at addresses 3..NO_REGISTERS+2
- NO_INTERRUPTS, 1, interrupt bits (bits NO_INTERRUPTS:1 of addr 0/2); < AV_DATA_WIDTH
- POLL_LIMIT, 255, maximum status polls before timeout (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  pulse: apply cfg_data; latched if busy
- cfg_data  in  AV_DATA_WIDTH*NO_REGISTERS  config words; word i at bits [i*W+W-1:i*W]; sampled when the write of word i issues
- irq_en  in  NO_INTERRUPTS  interrupt enables written with the go bit
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse: reconfiguration complete
- timeout  out  1  one-cycle pulse: stop poll exhausted
- irq_flags  out  NO_INTERRUPTS  last serviced interrupt bits (held)
- irq_pulse  out  1  one-cycle pulse: irq_flags updated
- m_address  out  AV_ADDRESS_WIDTH  slave address
- m_read  out  1  read strobe, one cycle
- m_readdata  in  AV_DATA_WIDTH  slave data, valid the cycle after m_read
- m_write  out  1  write strobe, one cycle
- m_writedata  out  AV_DATA_WIDTH  write data
- m_irq  in  1  slave interrupt

Behaviour:
- Reset: state IDLE; all outputs 0; start_pend, poll counter, word index, irq_flags cleared. Reset mid-sequence abandons it; the slave is not touched.
- Slave has no waitrequest: every strobe completes in its own cycle. Read data is sampled exactly one cycle after m_read. m_read and m_write are never high together.
- start_pend is set by start in any state, cleared on entry to STOP. A start during a sequence causes exactly one re-run after done or timeout.
- IDLE: if m_irq, go to IRQ_RD. Else if start_pend or start, go to STOP. An interrupt wins a tie; start stays pending.
- STOP: write addr 0, data {0.., irq_en, 1'b0}. Go to POLL_RD.
- POLL_RD: read addr 1. Go to POLL_CHK.
- POLL_CHK: if m_readdata[0]=1, clear the index and go to WR_REG. Else increment the poll counter. If the count reaches POLL_LIMIT, pulse timeout and go to IDLE. Otherwise go to POLL_RD. Counter width is clog2(POLL_LIMIT+1); the counter clears on entry to STOP.
- WR_REG: write addr index+3 with cfg_data word index. When index = NO_REGISTERS-1, go to ENABLE; else increment index. This gives NO_REGISTERS consecutive write cycles.
- ENABLE: write addr 0, data {0.., irq_en, 1'b1}. Pulse done next cycle; go to IDLE.
- IRQ_RD: read addr 2. Go to IRQ_CHK.
- IRQ_CHK: irq_flags <= m_readdata[NO_INTERRUPTS:1]; pulse irq_pulse. Go to IRQ_CLR.
- IRQ_CLR: write addr 2 with the captured readdata (clear only what was seen). Return to IDLE.
- If m_irq is still high in IDLE after IRQ_CLR, it is serviced again. If the captured value is 0, still clear and pulse.
- m_address and m_writedata are 0 when no strobe is active.
- Minimum sequence latency from start in IDLE to done: 1 (STOP) + 2 per poll + NO_REGISTERS + 1 (ENABLE) + 1 cycles = 9 cycles for one poll with defaults.

Decomposition:
- Shared package vipitc_ctrl_pkg: address constants ADDR_GO=0, ADDR_STATUS=1, ADDR_IRQ=2, ADDR_REG_BASE=3; state enum; clog2 function.
- No sub-module; single FSM plus counters.

Test Plan:
- Stopped on first poll (defaults), start pulse, cfg_data={16'h4444,16'h3333,16'h2222,16'h1111}, irq_en=1 -> writes (0,16'h0002), read 1, writes (3,1111), (4,2222), (5,3333), (6,4444), (0,16'h0003); done 9 cycles after start.
- Stopped asserts only on the 4th poll -> exactly 4 reads of addr 1 before the first addr-3 write; no timeout.
- Stopped never asserted, POLL_LIMIT=3 -> 3 polls, timeout pulse, busy falls, no writes to addr >= 3.
- m_irq high in IDLE, addr 2 reads 16'h0002 -> irq_flags=1, irq_pulse, write (2,16'h0002); slave irq drops.
- start and m_irq in the same IDLE cycle -> interrupt service first, then full config sequence with no second start needed.
- Second start during WR_REG, then rst_n low mid-sequence on a later run -> exactly one re-run after done; on reset, outputs 0 and state IDLE immediately (asynchronous).

Source files
------------

// File: rtl/vipitc_ctrl_pkg.sv
// Shared definitions for the clocked-video-output control sequencer.
// - Word addresses of the control slave (go, status, interrupt, register bank).
// - FSM state enumeration.
// - clog2 helper used to size the poll counter and the register index.
package vipitc_ctrl_pkg;

  localparam int ADDR_GO       = 0;
  localparam int ADDR_STATUS   = 1;
  localparam int ADDR_IRQ      = 2;
  localparam int ADDR_REG_BASE = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STOP,
    ST_POLL_RD,
    ST_POLL_CHK,
    ST_WR_REG,
    ST_ENABLE,
    ST_IRQ_RD,
    ST_IRQ_CHK,
    ST_IRQ_CLR
  } state_t;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/vipitc_ctrl_sequencer.sv
// Avalon-MM master that reconfigures a clocked-video-output control slave.
// On start: stop the slave (go=0), poll status until bit 0 reports stopped,
// write NO_REGISTERS config words to addresses 3.., then re-enable (go=1).
// While idle, slave interrupts are read, reported on irq_flags/irq_pulse and
// cleared by writing the captured value back.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request a reconfiguration (remembered while busy)
//   cfg_data            NO_REGISTERS words, word i at [i*W +: W]
//   irq_en              interrupt enables written alongside the go bit
//   busy                high whenever the FSM is not idle
//   done / timeout      one-cycle completion / stop-poll-exhausted pulses
//   irq_flags/irq_pulse last serviced interrupt bits and their update pulse
//   m_*                 Avalon-MM master (no waitrequest, read latency 1)
//
// Bus handshake: the slave has no waitrequest, so m_read / m_write are
// single-cycle strobes that always complete; read data is sampled exactly one
// cycle after m_read. At most one strobe is high per cycle, and m_address /
// m_writedata are zero whenever neither strobe is high.
module vipitc_ctrl_sequencer
  import vipitc_ctrl_pkg::*;
#(
  parameter int AV_ADDRESS_WIDTH = 5,
  parameter int AV_DATA_WIDTH    = 16,
  parameter int NO_REGISTERS     = 4,
  parameter int NO_INTERRUPTS    = 1,
  parameter int POLL_LIMIT       = 255
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [AV_DATA_WIDTH*NO_REGISTERS-1:0] cfg_data,
  input  logic [NO_INTERRUPTS-1:0]              irq_en,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  timeout,
  output logic [NO_INTERRUPTS-1:0]              irq_flags,
  output logic                                  irq_pulse,
  output logic [AV_ADDRESS_WIDTH-1:0]           m_address,
  output logic                                  m_read,
  input  logic [AV_DATA_WIDTH-1:0]              m_readdata,
  output logic                                  m_write,
  output logic [AV_DATA_WIDTH-1:0]              m_writedata,
  input  logic                                  m_irq
);

  localparam int CNT_W = clog2(POLL_LIMIT + 1);
  localparam int IDX_W = (NO_REGISTERS > 1) ? clog2(NO_REGISTERS) : 1;
  localparam logic [CNT_W-1:0] POLL_MAX = CNT_W'(POLL_LIMIT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NO_REGISTERS - 1);

  state_t                     state_q, state_d;
  logic                       start_pend_q, start_pend_d;
  logic [CNT_W-1:0]           poll_cnt_q, poll_cnt_d;
  logic [CNT_W-1:0]           poll_inc;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NO_INTERRUPTS-1:0]   irq_flags_q, irq_flags_d;
  logic [AV_DATA_WIDTH-1:0]   irq_data_q, irq_data_d;
  logic                       done_q, done_d;
  logic                       timeout_q, timeout_d;
  logic                       irq_pulse_q, irq_pulse_d;

  logic                       rd, wr;
  logic [AV_ADDRESS_WIDTH-1:0] addr;
  logic [AV_DATA_WIDTH-1:0]   wdata;
  logic [AV_DATA_WIDTH-1:0]   en_word;

  // Go-register image without the go bit: enables sit in bits NO_INTERRUPTS:1.
  always_comb begin
    en_word = '0;
    en_word[NO_INTERRUPTS:1] = irq_en;
  end

  assign poll_inc = poll_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q | start;
    poll_cnt_d   = poll_cnt_q;
    idx_d        = idx_q;
    irq_flags_d  = irq_flags_q;
    irq_data_d   = irq_data_q;
    done_d       = 1'b0;
    timeout_d    = 1'b0;
    irq_pulse_d  = 1'b0;
    rd           = 1'b0;
    wr           = 1'b0;
    addr         = '0;
    wdata        = '0;

    case (state_q)
      ST_IDLE: begin
        // Interrupt service wins a tie; the start stays pending.
        if (m_irq) begin
          state_d = ST_IRQ_RD;
        end else if (start_pend_q || start) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        wr      = 1'b1;
        addr    = AV_ADDRESS_WIDTH'(ADDR_GO);
        wdata   = en_word;
        state_d = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        rd      = 1'b1;
        addr    = AV_ADDRESS_WIDTH'(ADDR_STATUS);
        state_d = ST_POLL_CHK;
      end
      ST_POLL_CHK: begin
        if (m_readdata[0]) begin
          idx_d   = '0;
          state_d = ST_WR_REG;
        end else begin
          poll_cnt_d = poll_inc;
          if (poll_inc == POLL_MAX) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            state_d = ST_POLL_RD;
          end
        end
      end
      ST_WR_REG: begin
        wr    = 1'b1;
        addr  = AV_ADDRESS_WIDTH'(ADDR_REG_BASE) + AV_ADDRESS_WIDTH'(idx_q);
        wdata = cfg_data[int'(idx_q)*AV_DATA_WIDTH +: AV_DATA_WIDTH];
        if (idx_q == IDX_LAST) begin
          state_d = ST_ENABLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_ENABLE: begin
        wr      = 1'b1;
        addr    = AV_ADDRESS_WIDTH'(ADDR_GO);
        wdata   = en_word | AV_DATA_WIDTH'(1);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_IRQ_RD: begin
        rd      = 1'b1;
        addr    = AV_ADDRESS_WIDTH'(ADDR_IRQ);
        state_d = ST_IRQ_CHK;
      end
      ST_IRQ_CHK: begin
        irq_flags_d = m_readdata[NO_INTERRUPTS:1];
        irq_data_d  = m_readdata;
        irq_pulse_d = 1'b1;
        state_d     = ST_IRQ_CLR;
      end
      ST_IRQ_CLR: begin
        // Write back exactly the bits that were read so a newly raised
        // interrupt is not lost.
        wr      = 1'b1;
        addr    = AV_ADDRESS_WIDTH'(ADDR_IRQ);
        wdata   = irq_data_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Entering STOP consumes the pending request and restarts the poll count;
    // a start arriving any later schedules exactly one re-run.
    if (state_d == ST_STOP && state_q != ST_STOP) begin
      start_pend_d = 1'b0;
      poll_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      start_pend_q <= 1'b0;
      poll_cnt_q   <= '0;
      idx_q        <= '0;
      irq_flags_q  <= '0;
      irq_data_q   <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      irq_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      poll_cnt_q   <= poll_cnt_d;
      idx_q        <= idx_d;
      irq_flags_q  <= irq_flags_d;
      irq_data_q   <= irq_data_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      irq_pulse_q  <= irq_pulse_d;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign irq_flags   = irq_flags_q;
  assign irq_pulse   = irq_pulse_q;
  assign m_read      = rd;
  assign m_write     = wr;
  assign m_address   = addr;
  assign m_writedata = wdata;

endmodule
